// File: rtl/ktop_axis_pkg.sv
// ktop_axis_pkg
// Shared constants and helpers for the kernel transmit-side word packer.
//   C_DEF_TDATA_WIDTH / C_DEF_WORD_WIDTH : default beat and word widths
//   LP_LANES      : words per output beat at the default widths
//   LP_LANE_BYTES : bytes per word (tkeep bits per lane)
//   LP_KEEP_WIDTH : tkeep width at the default beat width
//   lanes_of / lane_bytes_of / keep_width_of : the same values for any widths
//   lane_lsb      : bit offset of a lane inside a beat (lane-slice helper)
package ktop_axis_pkg;

  localparam int unsigned C_DEF_TDATA_WIDTH = 512;
  localparam int unsigned C_DEF_WORD_WIDTH  = 32;
  localparam int unsigned LP_LANES          = C_DEF_TDATA_WIDTH / C_DEF_WORD_WIDTH;
  localparam int unsigned LP_LANE_BYTES     = C_DEF_WORD_WIDTH / 8;
  localparam int unsigned LP_KEEP_WIDTH     = C_DEF_TDATA_WIDTH / 8;

  function automatic int unsigned lanes_of(input int unsigned tdata_w, input int unsigned word_w);
    return tdata_w / word_w;
  endfunction

  function automatic int unsigned lane_bytes_of(input int unsigned word_w);
    return word_w / 8;
  endfunction

  function automatic int unsigned keep_width_of(input int unsigned tdata_w);
    return tdata_w / 8;
  endfunction

  // Lane k occupies bits [k*width +: width]; the same rule applies to tkeep
  // when width is the number of bytes per lane.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/ktop_axis_out_reg.sv
// ktop_axis_out_reg
// Single-stage AXI4-Stream output register. A beat is loaded when the packer
// completes one; it is held stable while the downstream stalls, and the
// upstream is told it may proceed whenever the stage is empty or draining.
// Ports:
//   aclk, aresetn          : clock, asynchronous active-low reset
//   load                   : a completed beat is presented this cycle
//   load_data/keep/last    : contents of that beat
//   m_axis_tready          : downstream ready
//   m_axis_tvalid/tdata/tkeep/tlast : registered output beat
//   in_ready               : ~out_valid | m_axis_tready (combinational)
module ktop_axis_out_reg #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned KEEP_W = 64
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [KEEP_W-1:0] load_keep,
  input  logic              load_last,
  input  logic              m_axis_tready,
  output logic              m_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              in_ready
);

  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic [KEEP_W-1:0] out_keep_r;
  logic              out_last_r;

  // Loads can only occur while in_ready is high, so a stalled beat is never
  // overwritten; a load in the same cycle as a drain keeps valid asserted.
  assign in_ready = ~out_valid_r | m_axis_tready;

  // Output stage: load a new beat, drain on handshake, otherwise hold.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_keep_r  <= '0;
      out_last_r  <= 1'b0;
    end else if (load) begin
      out_valid_r <= 1'b1;
      out_data_r  <= load_data;
      out_keep_r  <= load_keep;
      out_last_r  <= load_last;
    end else if (out_valid_r && m_axis_tready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign m_axis_tvalid = out_valid_r;
  assign m_axis_tdata  = out_data_r;
  assign m_axis_tkeep  = out_keep_r;
  assign m_axis_tlast  = out_last_r;

endmodule

// File: rtl/ktop_axis_word_packer.sv
// ktop_axis_word_packer
// Packs a stream of narrow result words, lane 0 first, into full-width
// AXI4-Stream beats. A beat is emitted when its last lane fills or when the
// input tlast arrives; unfilled lanes of a partial beat carry zero data and
// zero keep.
// Ports:
//   aclk, aresetn                        : clock, asynchronous active-low reset
//   s_axis_tvalid/tready/tdata/tlast     : narrow input word stream
//   m_axis_tvalid/tready/tdata/tkeep/tlast : wide output beat stream
//   stat_beat_count                      : completed m_axis handshakes (wraps)
module ktop_axis_word_packer
  import ktop_axis_pkg::*;
#(
  parameter int unsigned C_AXIS_TDATA_WIDTH = C_DEF_TDATA_WIDTH,
  parameter int unsigned C_WORD_WIDTH       = C_DEF_WORD_WIDTH,
  parameter int unsigned C_CNT_WIDTH        = 32
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_WORD_WIDTH-1:0]         s_axis_tdata,
  input  logic                            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic [C_CNT_WIDTH-1:0]          stat_beat_count
);

  localparam int unsigned P_LANES      = lanes_of(C_AXIS_TDATA_WIDTH, C_WORD_WIDTH);
  localparam int unsigned P_LANE_BYTES = lane_bytes_of(C_WORD_WIDTH);
  localparam int unsigned P_KEEP_W     = keep_width_of(C_AXIS_TDATA_WIDTH);
  localparam int unsigned P_IDX_W      = (P_LANES > 1) ? $clog2(P_LANES) : 1;
  localparam logic [P_IDX_W-1:0] P_LAST_IDX = P_IDX_W'(P_LANES - 1);

  logic [P_IDX_W-1:0]            idx_r;
  logic [C_AXIS_TDATA_WIDTH-1:0] acc_data_r;
  logic [P_KEEP_W-1:0]           acc_keep_r;
  logic [C_CNT_WIDTH-1:0]        beat_cnt_r;

  logic                          in_hs_s;
  logic                          complete_s;
  logic [C_AXIS_TDATA_WIDTH-1:0] acc_data_nx_s;
  logic [P_KEEP_W-1:0]           acc_keep_nx_s;

  assign in_hs_s    = s_axis_tvalid & s_axis_tready;
  assign complete_s = in_hs_s & ((idx_r == P_LAST_IDX) | s_axis_tlast);

  // Accumulator including the word being accepted this cycle; this is what a
  // completing word hands to the output stage.
  always_comb begin
    acc_data_nx_s = acc_data_r;
    acc_keep_nx_s = acc_keep_r;
    if (in_hs_s) begin
      acc_data_nx_s[lane_lsb(32'(idx_r), C_WORD_WIDTH) +: C_WORD_WIDTH] = s_axis_tdata;
      acc_keep_nx_s[lane_lsb(32'(idx_r), P_LANE_BYTES) +: P_LANE_BYTES] = {P_LANE_BYTES{1'b1}};
    end else begin
      acc_data_nx_s = acc_data_r;
      acc_keep_nx_s = acc_keep_r;
    end
  end

  // Lane index and accumulator: clear after a completed beat so the next
  // packet always starts in lane 0 with no stale lanes.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      idx_r      <= '0;
      acc_data_r <= '0;
      acc_keep_r <= '0;
    end else if (complete_s) begin
      idx_r      <= '0;
      acc_data_r <= '0;
      acc_keep_r <= '0;
    end else if (in_hs_s) begin
      idx_r      <= idx_r + P_IDX_W'(1);
      acc_data_r <= acc_data_nx_s;
      acc_keep_r <= acc_keep_nx_s;
    end
  end

  // Completed output handshakes, wrapping at the counter width.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_cnt_r <= '0;
    end else if (m_axis_tvalid && m_axis_tready) begin
      beat_cnt_r <= beat_cnt_r + C_CNT_WIDTH'(1);
    end
  end

  assign stat_beat_count = beat_cnt_r;

  ktop_axis_out_reg #(
    .DATA_W (C_AXIS_TDATA_WIDTH),
    .KEEP_W (P_KEEP_W)
  ) u_out_reg (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .load          (complete_s),
    .load_data     (acc_data_nx_s),
    .load_keep     (acc_keep_nx_s),
    .load_last     (s_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .in_ready      (s_axis_tready)
  );

endmodule

// File: tb/tb_ktop_axis_word_packer.sv
// Directed bench for ktop_axis_word_packer: a table of packets with
// hand-computed beat counts and final-beat keep masks, plus hand-written
// sequences for backpressure and reset in the middle of a packet.
module tb_ktop_axis_word_packer;
  import ktop_axis_pkg::*;

  logic         aclk;
  logic         aresetn;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [31:0]  s_axis_tdata;
  logic         s_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tlast;
  logic [31:0]  stat_beat_count;

  ktop_axis_word_packer dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tlast    (s_axis_tlast),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tkeep    (m_axis_tkeep),
    .m_axis_tlast    (m_axis_tlast),
    .stat_beat_count (stat_beat_count)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;

  logic [511:0] got_data[$];
  logic [63:0]  got_keep[$];
  logic         got_last[$];

  // Capture every accepted output beat (ready is driven away from the edge).
  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      got_data.push_back(m_axis_tdata);
      got_keep.push_back(m_axis_tkeep);
      got_last.push_back(m_axis_tlast);
    end
  end

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Present one word and wait (bounded) for its handshake.
  task automatic send_word(input logic [31:0] d, input logic l, output int stalls);
    bit done;
    stalls = 0;
    done = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    for (int t = 0; t < 200; t++) begin
      @(negedge aclk);
      if (s_axis_tready) begin
        done = 1'b1;
        break;
      end
      stalls++;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: word %0h never accepted", d);
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Expected beat b of a packet whose words are first, first+1, ...
  function automatic logic [511:0] exp_beat(input logic [31:0] first, input int n, input int b);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      int w;
      w = b * 16 + k;
      if (w < n) r[k*32 +: 32] = first + 32'(w);
    end
    return r;
  endfunction

  typedef struct {
    int          n_words;
    logic [31:0] first;
    int          n_beats;
    logic [63:0] last_keep;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [63:0]  full_keep;
    logic [511:0] lane0;
    logic [511:0] held;
    int           st;
    int           stalls;
    int           exp_count;

    full_keep = 64'hFFFF_FFFF_FFFF_FFFF;
    vecs[0] = '{16, 32'h0000_0001, 1, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[1] = '{20, 32'h0000_0001, 2, 64'h0000_0000_0000_FFFF};
    vecs[2] = '{1,  32'hDEAD_BEEF, 1, 64'h0000_0000_0000_000F};
    vecs[3] = '{48, 32'h0000_1000, 3, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[4] = '{17, 32'h0000_0100, 2, 64'h0000_0000_0000_000F};
    vecs[5] = '{7,  32'h0000_00A0, 1, 64'h0000_0000_0FFF_FFFF};

    aclk          = 1'b0;
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 32'h0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    exp_count     = 0;

    @(negedge aclk);
    check("rst_tvalid", 512'(m_axis_tvalid), 512'd0);
    check("rst_tdata", m_axis_tdata, 512'd0);
    check("rst_tkeep", 512'(m_axis_tkeep), 512'd0);
    check("rst_tlast", 512'(m_axis_tlast), 512'd0);
    check("rst_count", 512'(stat_beat_count), 512'd0);
    check("rst_s_ready", 512'(s_axis_tready), 512'd1);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Table of packets with downstream always ready.
    for (int i = 0; i < 6; i++) begin
      got_data.delete();
      got_keep.delete();
      got_last.delete();
      stalls = 0;
      for (int w = 0; w < vecs[i].n_words; w++) begin
        send_word(vecs[i].first + 32'(w), (w == vecs[i].n_words - 1), st);
        stalls += st;
      end
      // Final beat must be on m_axis in the cycle after the last handshake.
      @(negedge aclk);
      check($sformatf("v%0d_lat_valid", i), 512'(m_axis_tvalid), 512'd1);
      check($sformatf("v%0d_lat_last", i), 512'(m_axis_tlast), 512'd1);
      repeat (3) @(negedge aclk);
      exp_count += vecs[i].n_beats;
      check($sformatf("v%0d_stalls", i), 512'(stalls), 512'd0);
      check($sformatf("v%0d_nbeats", i), 512'(got_data.size()), 512'(vecs[i].n_beats));
      for (int b = 0; b < vecs[i].n_beats && b < got_data.size(); b++) begin
        check($sformatf("v%0d_b%0d_data", i, b), got_data[b], exp_beat(vecs[i].first, vecs[i].n_words, b));
        check($sformatf("v%0d_b%0d_keep", i, b), 512'(got_keep[b]),
              512'((b == vecs[i].n_beats - 1) ? vecs[i].last_keep : full_keep));
        check($sformatf("v%0d_b%0d_last", i, b), 512'(got_last[b]),
              512'(b == vecs[i].n_beats - 1));
      end
      check($sformatf("v%0d_count", i), 512'(stat_beat_count), 512'(exp_count));
      @(posedge aclk);
      #1;
    end

    // Backpressure: a full beat held for 5 cycles while the next word waits.
    got_data.delete();
    got_keep.delete();
    got_last.delete();
    m_axis_tready = 1'b0;
    for (int w = 0; w < 16; w++) begin
      send_word(32'h0000_0200 + 32'(w), (w == 15), st);
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'h0000_00AA;
    s_axis_tlast  = 1'b1;
    held = exp_beat(32'h0000_0200, 16, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      check($sformatf("bp%0d_s_ready", c), 512'(s_axis_tready), 512'd0);
      check($sformatf("bp%0d_tvalid", c), 512'(m_axis_tvalid), 512'd1);
      check($sformatf("bp%0d_tdata", c), m_axis_tdata, held);
      check($sformatf("bp%0d_tkeep", c), 512'(m_axis_tkeep), 512'(full_keep));
      check($sformatf("bp%0d_tlast", c), 512'(m_axis_tlast), 512'd1);
      @(posedge aclk);
      #1;
    end
    m_axis_tready = 1'b1;
    @(negedge aclk);
    check("bp_release_s_ready", 512'(s_axis_tready), 512'd1);
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    lane0 = 512'h0;
    lane0[31:0] = 32'h0000_00AA;
    @(negedge aclk);
    check("bp_next_tvalid", 512'(m_axis_tvalid), 512'd1);
    check("bp_next_tdata", m_axis_tdata, lane0);
    check("bp_next_tkeep", 512'(m_axis_tkeep), 512'h000F);
    check("bp_next_tlast", 512'(m_axis_tlast), 512'd1);
    repeat (2) @(negedge aclk);
    exp_count += 2;
    check("bp_nbeats", 512'(got_data.size()), 512'd2);
    check("bp_count", 512'(stat_beat_count), 512'(exp_count));
    @(posedge aclk);
    #1;

    // Reset in the middle of a packet, then a one-word packet.
    for (int w = 0; w < 5; w++) begin
      send_word(32'h0000_0300 + 32'(w), 1'b0, st);
    end
    #1;
    aresetn = 1'b0;
    #1;
    check("mid_rst_tvalid", 512'(m_axis_tvalid), 512'd0);
    check("mid_rst_tdata", m_axis_tdata, 512'd0);
    check("mid_rst_tkeep", 512'(m_axis_tkeep), 512'd0);
    check("mid_rst_tlast", 512'(m_axis_tlast), 512'd0);
    check("mid_rst_count", 512'(stat_beat_count), 512'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    send_word(32'h0000_0055, 1'b1, st);
    lane0 = 512'h0;
    lane0[31:0] = 32'h0000_0055;
    @(negedge aclk);
    check("post_rst_tvalid", 512'(m_axis_tvalid), 512'd1);
    check("post_rst_tdata", m_axis_tdata, lane0);
    check("post_rst_tkeep", 512'(m_axis_tkeep), 512'h000F);
    check("post_rst_tlast", 512'(m_axis_tlast), 512'd1);
    repeat (2) @(negedge aclk);
    check("post_rst_count", 512'(stat_beat_count), 512'd1);
    check("pkg_lanes", 512'(LP_LANES * LP_LANE_BYTES), 512'(64));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
